// File: rtl/draw_pkg.sv
// +----------------------------------------------------------------------------+
// | draw_pkg : shared types and defaults for the draw_sched command scheduler  |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

package draw_pkg;

  localparam int CMD_WW = 12;
  localparam int CMD_HW = 12;
  localparam int DEF_W  = 400;
  localparam int DEF_H  = 300;

  typedef struct packed {
    logic [CMD_WW-1:0] w;
    logic [CMD_HW-1:0] h;
  } cmd_t;

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/cmd_fifo.sv
// +----------------------------------------------------------------------------+
// | cmd_fifo : generic synchronous FIFO, DEPTH entries (power of 2, >=2)       |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module cmd_fifo
  import draw_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_WW + CMD_HW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_level == (AW+1)'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/draw_sched.sv
// +----------------------------------------------------------------------------+
// | draw_sched : per-frame launch scheduler for the line-drawing engine        |
// | Optional   : DRAW_SCHED_STATS_EN enables frame_cnt / overrun_cnt counters  |
// | Rev 1.0    : initial release                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module draw_sched
  import draw_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WW    = CMD_WW,
  parameter int HW    = CMD_HW,
  parameter int CNT_W = 16,
  parameter int DEF_W = draw_pkg::DEF_W,
  parameter int DEF_H = draw_pkg::DEF_H
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WW-1:0]          cmd_w,
  input  logic [HW-1:0]          cmd_h,
  input  logic                   vtrigger,
  input  logic                   eng_done,
  output logic                   eng_trigger,
  output logic [WW-1:0]          eng_w,
  output logic [HW-1:0]          eng_h,
  output logic                   busy,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] q_level,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic [CNT_W-1:0]       overrun_cnt
);

  localparam logic [0:0] c_WAIT = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic               r_trigger;
  logic               r_overrun;
  logic [WW-1:0]      r_w;
  logic [HW-1:0]      r_h;
  logic [WW+HW-1:0]   w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_launch;
  logic               w_overrun;

  assign w_push    = cmd_valid && !w_full;
  // A done arriving alongside vtrigger frees the engine for this frame.
  assign w_launch  = vtrigger && ((r_state == c_WAIT) || eng_done);
  assign w_overrun = vtrigger && (r_state == c_RUN) && !eng_done;
  assign w_pop     = w_launch && !w_empty;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WW + HW)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({cmd_w, cmd_h}),
    .dout  (w_head),
    .level (q_level),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_WAIT;
      r_trigger <= 1'b0;
      r_overrun <= 1'b0;
      r_w       <= WW'(DEF_W);
      r_h       <= HW'(DEF_H);
    end else begin
      r_trigger <= w_launch;
      r_overrun <= w_overrun;
      if (w_launch) begin
        r_state <= c_RUN;
        if (!w_empty) begin
          r_w <= w_head[WW+HW-1:HW];
          r_h <= w_head[HW-1:0];
        end
      end else if ((r_state == c_RUN) && eng_done) begin
        r_state <= c_WAIT;
      end
    end
  end

  assign cmd_ready   = !w_full;
  assign eng_trigger = r_trigger;
  assign eng_w       = r_w;
  assign eng_h       = r_h;
  assign busy        = (r_state == c_RUN);
  assign overrun     = r_overrun;

`ifdef DRAW_SCHED_STATS_EN
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_overrun_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt   <= '0;
      r_overrun_cnt <= '0;
    end else begin
      if (w_launch) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_overrun) begin
        r_overrun_cnt <= r_overrun_cnt + 1'b1;
      end
    end
  end

  assign frame_cnt   = r_frame_cnt;
  assign overrun_cnt = r_overrun_cnt;
`else
  assign frame_cnt   = '0;
  assign overrun_cnt = '0;
`endif

endmodule

`default_nettype wire
